// File: rtl/rsa_msg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : rsa_msg_sequencer
//  Description : Queues plaintext messages, issues them one at a time to an
//                external RSA encryptor with the latched public key, and
//                returns tagged ciphertexts through a valid/ready port.
//  Revision    : 1.0 - initial release
// ============================================================================
module rsa_msg_sequencer #(
   parameter int WIDTH       = 8,
   parameter int DEPTH       = 4,
   parameter int TIMEOUT_CYC = 20000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 key_load,
   input  logic [WIDTH-1:0]     key_e,
   input  logic [2*WIDTH-1:0]   key_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2*WIDTH-1:0]   in_m,
   output logic                 enc_start,
   output logic [2*WIDTH-1:0]   enc_m,
   output logic [WIDTH-1:0]     enc_e,
   output logic [2*WIDTH-1:0]   enc_n,
   input  logic [2*WIDTH-1:0]   enc_c,
   input  logic                 enc_finish,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_c,
   output logic [7:0]           out_tag,
   output logic                 key_err,
   output logic                 msg_err,
   output logic                 tmo_err,
   output logic                 busy
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0]      FIFO_FULL = CW'(DEPTH);
   localparam logic [TW-1:0]      TMO_LAST  = TW'(TIMEOUT_CYC - 1);
   localparam logic [2*WIDTH-1:0] N_MIN     = (2*WIDTH)'(2);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      OUT   = 2'd3
   } state_t;

   state_t               state;
   logic [WIDTH-1:0]     key_exp;
   logic [2*WIDTH-1:0]   key_mod;
   logic                 key_valid;
   logic [2*WIDTH-1:0]   mem [DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [CW-1:0]        count;
   logic [7:0]           seq;
   logic [TW-1:0]        tmo_cnt;
   logic                 enc_start_reg;
   logic                 out_valid_reg;
   logic                 key_err_reg;
   logic                 msg_err_reg;
   logic                 tmo_err_reg;

   logic                 full;
   logic                 empty;
   logic                 msg_ok;
   logic                 push;
   logic                 pop;
   logic                 key_ok;

   // Handshake qualification; a rejected message is consumed but never stored
   always_comb begin
      full   = (count == FIFO_FULL);
      empty  = (count == '0);
      msg_ok = key_valid && (in_m < key_mod);
      push   = in_valid && !full && msg_ok;
      pop    = (state == IDLE) && key_valid && !empty && !key_load;
      key_ok = (state == IDLE) && (key_e != '0) && (key_n >= N_MIN);
   end

   // Pulse/status outputs are forced quiet while reset is held
   assign in_ready  = rst | ~full;
   assign enc_start = enc_start_reg & ~rst;
   assign out_valid = out_valid_reg & ~rst;
   assign key_err   = key_err_reg & ~rst;
   assign msg_err   = msg_err_reg & ~rst;
   assign tmo_err   = tmo_err_reg & ~rst;
   assign busy      = (state != IDLE) & ~rst;

   // FIFO storage; contents are don't-care while the entry is not counted
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_m;
      end
   end

   // FIFO pointers and occupancy; simultaneous push and pop cancel in count
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
      end
   end

   // Key latch and key/message error pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         key_exp     <= '0;
         key_mod     <= '0;
         key_valid   <= 1'b0;
         key_err_reg <= 1'b0;
         msg_err_reg <= 1'b0;
      end else begin
         key_err_reg <= 1'b0;
         msg_err_reg <= in_valid && !full && !msg_ok;
         if (key_load) begin
            if (key_ok) begin
               key_exp   <= key_e;
               key_mod   <= key_n;
               key_valid <= 1'b1;
            end else begin
               key_err_reg <= 1'b1;
            end
         end
      end
   end

   // Transaction FSM: issue, wait for result or timeout, present ciphertext
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         enc_m         <= '0;
         enc_e         <= '0;
         enc_n         <= '0;
         out_c         <= '0;
         out_tag       <= '0;
         seq           <= '0;
         tmo_cnt       <= '0;
         enc_start_reg <= 1'b0;
         out_valid_reg <= 1'b0;
         tmo_err_reg   <= 1'b0;
      end else begin
         enc_start_reg <= 1'b0;
         tmo_err_reg   <= 1'b0;
         case (state)
            IDLE: begin
               if (pop) begin
                  enc_m         <= mem[rd_ptr];
                  enc_e         <= key_exp;
                  enc_n         <= key_mod;
                  enc_start_reg <= 1'b1;
                  state         <= ISSUE;
               end
            end
            ISSUE: begin
               tmo_cnt <= '0;
               state   <= WAIT;
            end
            WAIT: begin
               if (enc_finish) begin
                  out_c         <= enc_c;
                  out_tag       <= seq;
                  out_valid_reg <= 1'b1;
                  seq           <= seq + 8'd1;
                  state         <= OUT;
               end else if (tmo_cnt == TMO_LAST) begin
                  tmo_err_reg <= 1'b1;
                  seq         <= seq + 8'd1;
                  state       <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
